// File: rtl/rom_stream_reader_pkg.sv
// Shared definitions for the ROM stream reader: sequencer states,
// default geometry of the ROM and its output buffer, and sizing helpers.
package rom_stream_reader_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Default ROM geometry and buffering
    localparam int AW_DEF         = 8;
    localparam int DW_DEF         = 8;
    localparam int RD_LAT_DEF     = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    // Pointer width for a buffer of the given depth (never narrower than one bit)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rom_stream_reader_fifo.sv
// Small synchronous FIFO with a show-ahead head word, an occupancy count and
// a synchronous flush. Data appears at the head one cycle after it is written.
module stream_fifo
    import rom_stream_reader_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [DW-1:0]              wr_data_i,
    input  logic                       rd_en_i,
    output logic [DW-1:0]              rd_data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr;
    logic          do_rd;

    // A read request against an empty buffer is simply ignored
    assign do_wr = wr_en_i && !flush_i;
    assign do_rd = rd_en_i && (count_q != '0) && !flush_i;

    // Pointers wrap at DEPTH so non-power-of-two depths work too
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next pointers and occupancy; a simultaneous write and read leaves the count unchanged
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_wr && !do_rd) begin
                count_d = count_q + CW'(1);
            end else if (!do_wr && do_rd) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage is reset only because it is a few flops and the head must read 0 out of reset; a real RAM array would not be.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
            if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;

    // Upstream credit accounting must never write a full buffer unless the head is popped in the same cycle
    assert property (@(posedge clk) disable iff (!rst_n)
        !(do_wr && !do_rd && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/rom_stream_reader.sv
// Sequencer between the PLL/ROM pair and a valid/ready consumer. After PLL
// lock it sweeps an address range (once or repeatedly), tracks the ROM read
// latency with a valid shift register and re-emits the returned words through
// a small FIFO. Addresses are issued only when the FIFO is guaranteed room
// for the word when it comes back, so backpressure never loses data.
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          locked,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          abort
);

    // In-flight words: the address on the bus plus RD_LAT pipeline stages
    localparam int IW = $clog2(RD_LAT + 2);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q;
    logic [AW-1:0]     cur_q;
    logic [AW-1:0]     start_q;
    logic [AW-1:0]     end_q;
    logic              loop_q;
    logic [AW-1:0]     rom_addr_q;
    logic              addr_vld_q;
    logic [RD_LAT-1:0] lat_q, lat_d;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic              done_q;
    logic              abort_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_valid;
    logic [DW-1:0]     fifo_head;
    logic              fifo_wr;
    logic              fifo_pop;
    logic              flush;

    logic              issue;
    logic              has_credit;
    logic [AW-1:0]     iss_addr;
    logic [AW-1:0]     iss_end;
    logic [AW-1:0]     iss_start;
    logic              iss_loop;
    logic              iss_last;
    logic              drain_done;

    // Lock loss while busy discards everything in flight and everything buffered
    assign flush    = (state_q != ST_IDLE) && !locked;
    assign fifo_wr  = lat_q[RD_LAT-1];
    assign fifo_pop = fifo_valid && out_ready;

    // Issue decision. The first address goes out on the start edge itself using the
    // live inputs; later addresses need credit. A pop in the current cycle frees a slot
    // long before the new word can land, which is what sustains one word per cycle.
    always_comb begin
        iss_addr   = cur_q;
        iss_end    = end_q;
        iss_start  = start_q;
        iss_loop   = loop_q;
        issue      = 1'b0;
        has_credit = (int'(fifo_count) + int'(inflight_q)) < (FIFO_DEPTH + int'(fifo_pop));
        case (state_q)
            ST_IDLE: begin
                iss_addr  = start_addr;
                iss_end   = end_addr;
                iss_start = start_addr;
                iss_loop  = loop;
                issue     = start && locked;
            end
            ST_RUN:  issue = locked && has_credit;
            default: issue = 1'b0;
        endcase
        iss_last = (iss_addr == iss_end);
    end

    // Latency shift register and in-flight counter, both cleared on a flush
    always_comb begin
        lat_d      = '0;
        inflight_d = '0;
        if (!flush) begin
            lat_d[0] = addr_vld_q;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_d[i] = lat_q[i-1];
            end
            inflight_d = inflight_q + IW'(issue) - IW'(fifo_wr);
        end
    end

    // DRAIN may finish once nothing is in flight and the buffer is empty after this cycle's pop
    assign drain_done = (inflight_d == '0)
                     && ((int'(fifo_count) + int'(fifo_wr) - int'(fifo_pop)) == 0);

    // Sequencer: state, address counter, latched sweep parameters and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            start_q    <= '0;
            end_q      <= '0;
            loop_q     <= 1'b0;
            rom_addr_q <= '0;
            addr_vld_q <= 1'b0;
            lat_q      <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            addr_vld_q <= issue;
            lat_q      <= lat_d;
            inflight_q <= inflight_d;

            // The bus holds the last issued address between issues
            if (issue) begin
                rom_addr_q <= iss_addr;
                cur_q      <= iss_last ? iss_start : iss_addr + AW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start && locked) begin
                        start_q <= start_addr;
                        end_q   <= end_addr;
                        loop_q  <= loop;
                        state_q <= (iss_last && !loop) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked) begin
                        state_q <= ST_IDLE;
                        abort_q <= 1'b1;
                    end else if (stop || (issue && iss_last && !loop_q)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!locked) begin
                        state_q <= ST_IDLE;
                        abort_q <= 1'b1;
                    end else if (drain_done) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    stream_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .wr_en_i   (fifo_wr),
        .wr_data_i (rom_q),
        .rd_en_i   (out_ready),
        .rd_data_o (fifo_head),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );

    assign rom_addr  = rom_addr_q;
    assign out_data  = fifo_head;
    assign out_valid = fifo_valid;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign abort     = abort_q;

    // The in-flight tracker can never hold more than the bus address plus RD_LAT stages
    assert property (@(posedge clk) disable iff (!rst_n) int'(inflight_q) <= RD_LAT + 1);

    // Completion and abort are mutually exclusive
    assert property (@(posedge clk) disable iff (!rst_n) !(done_q && abort_q));

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a table of sweeps (range, loop, ready pattern,
// stop point, expected word count and latencies) driven against a 2-cycle ROM
// model, plus hand-written lock-loss, unlocked-start and mid-run reset sequences.
module tb_rom_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] start_addr;
    logic [7:0] end_addr;
    logic [7:0] rom_addr;
    logic [7:0] rom_q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       abort;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] sa;
        logic [7:0] ea;
        logic       lp;
        int         ready_mode;  // 0: always ready, 1: ready one cycle in three
        int         stop_after;  // pulse stop the cycle after this many pops (0 = never)
        int         exp_words;
        int         exp_first;   // cycles from start to first pop (-1 = not checked)
        int         exp_done;    // cycles from start to done (-1 = not checked)
    } vec_t;

    vec_t vecs [6];

    rom_stream_reader #(
        .AW         (8),
        .DW         (8),
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: a bijection so every address returns a distinct word
    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h5A;
    endfunction

    // ROM model: registered address, registered output (2-cycle latency)
    logic [7:0] rom_areg;
    always @(posedge clk) begin
        rom_areg <= rom_addr;
        rom_q    <= rom_fn(rom_areg);
    end

    function automatic logic rdy(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 3) == 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one sweep from the table and compare the collected stream
    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] got [$];
        logic [7:0] diff;
        logic [7:0] a;
        int         wpp;
        int         first_lat = -1;
        int         done_lat  = -1;
        bit         stop_pend = 1'b0;
        int         budget;
        int         n;

        diff   = v.ea - v.sa;
        wpp    = int'(diff) + 1;
        budget = v.exp_words * 4 + 40;

        @(posedge clk); #1;
        start_addr = v.sa;
        end_addr   = v.ea;
        loop       = v.lp;
        start      = 1'b1;
        out_ready  = rdy(v.ready_mode, 0);

        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (k == 0) check($sformatf("v%0d_busy_at_start", idx), int'(busy), 0);
            if (k == 1) check($sformatf("v%0d_busy_after_start", idx), int'(busy), 1);
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (first_lat < 0) first_lat = k;
                if (v.stop_after > 0 && got.size() == v.stop_after) stop_pend = 1'b1;
            end
            if (done) begin
                done_lat = k;
                check($sformatf("v%0d_busy_at_done", idx), int'(busy), 0);
                break;
            end
            @(posedge clk); #1;
            start     = 1'b0;
            stop      = stop_pend;
            stop_pend = 1'b0;
            out_ready = rdy(v.ready_mode, k + 1);
        end
        start = 1'b0;
        stop  = 1'b0;

        if (done_lat < 0) check($sformatf("v%0d_done_timeout", idx), 0, 1);
        check($sformatf("v%0d_word_count", idx), got.size(), v.exp_words);
        n = (got.size() < v.exp_words) ? got.size() : v.exp_words;
        for (int i = 0; i < n; i++) begin
            a = v.sa + 8'(i % wpp);
            check($sformatf("v%0d_data%0d", idx, i), int'(got[i]), int'(rom_fn(a)));
        end
        if (v.exp_first >= 0) check($sformatf("v%0d_first_latency", idx), first_lat, v.exp_first);
        if (v.exp_done >= 0)  check($sformatf("v%0d_done_latency", idx), done_lat, v.exp_done);

        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", idx), int'(done), 0);
        check($sformatf("v%0d_valid_after_done", idx), int'(out_valid), 0);
    endtask

    // Global time limit so the bench can never hang
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pulse_seen;

        vecs[0] = '{8'h10, 8'h13, 1'b0, 0, 0,   4,  4,   8};
        vecs[1] = '{8'hFE, 8'h01, 1'b0, 0, 0,   4,  4,   8};
        vecs[2] = '{8'h00, 8'h0F, 1'b0, 1, 0,  16, -1,  -1};
        vecs[3] = '{8'h20, 8'h22, 1'b1, 0, 7,  12,  4,  16};
        vecs[4] = '{8'h05, 8'h05, 1'b0, 0, 0,   1,  4,   5};
        vecs[5] = '{8'h80, 8'h7F, 1'b0, 0, 0, 256,  4, 260};

        rst_n      = 1'b0;
        locked     = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        loop       = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        locked = 1'b1;
        @(negedge clk);
        check("rst_rom_addr",  int'(rom_addr),  0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy",      int'(busy),      0);
        check("rst_done",      int'(done),      0);
        check("rst_abort",     int'(abort),     0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Lock loss in the middle of a long single pass
        @(posedge clk); #1;
        start_addr = 8'h00;
        end_addr   = 8'hFF;
        loop       = 1'b0;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 locked = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("lock_abort_pulse", int'(abort),     1);
        check("lock_out_valid",   int'(out_valid), 0);
        check("lock_busy",        int'(busy),      0);
        check("lock_no_done",     int'(done),      0);
        @(negedge clk);
        check("lock_abort_one_cycle", int'(abort), 0);

        // Start while unlocked is ignored
        @(posedge clk); #1;
        start_addr = 8'h30;
        end_addr   = 8'h31;
        start      = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pulse_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy || out_valid || done || abort) pulse_seen = 1'b1;
        end
        check("unlocked_start_ignored", int'(pulse_seen), 0);

        // Relock and confirm nothing stale leaks into a fresh sweep
        locked = 1'b1;
        run_vec(vecs[0], 6);

        // Reset pulse in the middle of a long single pass
        @(posedge clk); #1;
        start_addr = 8'h00;
        end_addr   = 8'hFF;
        loop       = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mrst_rom_addr",  int'(rom_addr),  0);
        check("mrst_out_data",  int'(out_data),  0);
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_busy",      int'(busy),      0);
        check("mrst_done",      int'(done),      0);
        check("mrst_abort",     int'(abort),     0);
        pulse_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || abort || busy) pulse_seen = 1'b1;
        end
        check("mrst_no_pulse", int'(pulse_seen), 0);

        run_vec(vecs[1], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
